// File: rtl/prog_mem_loader.sv
// Instruction memory with a registered fetch port and a length-prefixed serial loader.
// Bytes from the UART are packed little-endian into words and written from address 0.
module prog_mem_loader #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 14,
   parameter int DEPTH  = 16384
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              fetch_en_i,
   input  logic [ADDR_W-1:0] fetch_adr_i,
   output logic [DATA_W-1:0] instr_o,
   output logic              instr_vld_o,
   input  logic              load_start_i,
   input  logic [7:0]        rx_dat_i,
   input  logic              rx_vld_i,
   output logic              rx_rdy_o,
   output logic              loading_o,
   output logic              done_o,
   output logic              err_o,
   output logic [ADDR_W:0]   word_cnt_o
);

   localparam int LANES = DATA_W / 8;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = ADDR_W + 1;

   typedef enum logic [1:0] {RUN, LEN0, LEN1, DATA} state_t;

   state_t              state_reg, state_next;
   logic [15:0]         len_reg, len_next;
   logic [LANE_W-1:0]   lane_reg, lane_next;
   logic [DATA_W-1:0]   shift_reg, shift_next;
   logic [IDX_W-1:0]    wr_adr_reg, wr_adr_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic                err_reg, err_next;
   logic                done_reg, done_next;
   logic                vld_reg, in_range_reg;
   logic [DATA_W-1:0]   rd_data_reg;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                accept, wr_en, in_range, rd_en, last_lane;
   logic [DATA_W-1:0]   asm_word;
   logic [CNT_W-1:0]    cnt_inc;
   logic [15:0]         full_len;

   assign loading_o   = (state_reg != RUN);
   assign rx_rdy_o    = (state_reg != RUN);
   assign accept      = rx_vld_i && (state_reg != RUN);
   assign last_lane   = (lane_reg == LANE_W'(LANES - 1));
   assign cnt_inc     = cnt_reg + CNT_W'(1);
   assign full_len    = {rx_dat_i, len_reg[7:0]};
   assign in_range    = ({1'b0, fetch_adr_i} < CNT_W'(DEPTH));
   assign rd_en       = fetch_en_i && (state_reg == RUN) && in_range;

   assign done_o      = done_reg;
   assign err_o       = err_reg;
   assign word_cnt_o  = cnt_reg;
   assign instr_vld_o = vld_reg;
   // Out-of-range fetches still complete, but return zero.
   assign instr_o     = (vld_reg && in_range_reg) ? rd_data_reg : '0;

   always_comb begin
      asm_word = shift_reg;
      for (int k = 0; k < LANES; k++) begin
         if (lane_reg == LANE_W'(k)) asm_word[8*k +: 8] = rx_dat_i;
      end
   end

   always_comb begin
      state_next  = state_reg;
      len_next    = len_reg;
      lane_next   = lane_reg;
      shift_next  = shift_reg;
      wr_adr_next = wr_adr_reg;
      cnt_next    = cnt_reg;
      err_next    = err_reg;
      done_next   = 1'b0;
      wr_en       = 1'b0;
      // A start request overrides any byte accepted in the same cycle.
      if (load_start_i) begin
         state_next  = LEN0;
         lane_next   = '0;
         shift_next  = '0;
         wr_adr_next = '0;
         cnt_next    = '0;
         err_next    = 1'b0;
      end else begin
         case (state_reg)
            LEN0: begin
               if (accept) begin
                  len_next   = {8'h00, rx_dat_i};
                  state_next = LEN1;
               end
            end
            LEN1: begin
               if (accept) begin
                  len_next = full_len;
                  if (full_len == 16'd0) begin
                     state_next = RUN;
                     done_next  = 1'b1;
                  end else if ({1'b0, full_len} > 17'(DEPTH)) begin
                     state_next = RUN;
                     err_next   = 1'b1;
                  end else begin
                     state_next = DATA;
                  end
               end
            end
            DATA: begin
               if (accept) begin
                  if (last_lane) begin
                     wr_en       = 1'b1;
                     wr_adr_next = wr_adr_reg + IDX_W'(1);
                     cnt_next    = cnt_inc;
                     lane_next   = '0;
                     shift_next  = '0;
                     if (17'(cnt_inc) == {1'b0, len_reg}) begin
                        state_next = RUN;
                        done_next  = 1'b1;
                     end
                  end else begin
                     shift_next = asm_word;
                     lane_next  = lane_reg + LANE_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg    <= RUN;
         len_reg      <= '0;
         lane_reg     <= '0;
         shift_reg    <= '0;
         wr_adr_reg   <= '0;
         cnt_reg      <= '0;
         err_reg      <= 1'b0;
         done_reg     <= 1'b0;
         vld_reg      <= 1'b0;
         in_range_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         len_reg      <= len_next;
         lane_reg     <= lane_next;
         shift_reg    <= shift_next;
         wr_adr_reg   <= wr_adr_next;
         cnt_reg      <= cnt_next;
         err_reg      <= err_next;
         done_reg     <= done_next;
         vld_reg      <= fetch_en_i && (state_reg == RUN);
         in_range_reg <= in_range;
      end
   end

   // RAM kept free of reset so it maps onto block memory.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_adr_reg] <= asm_word;
      if (rd_en) rd_data_reg <= mem[fetch_adr_i[IDX_W-1:0]];
   end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed + randomized bench for prog_mem_loader; expected memory image and
// status are derived from the byte streams by a simple reference model.
module tb_prog_mem_loader;

   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int DEP = 16;

   typedef logic [7:0] bq_t [$];

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          fetch_en = 1'b0;
   logic [AW-1:0] fetch_adr = '0;
   logic [DW-1:0] instr;
   logic          instr_vld;
   logic          load_start = 1'b0;
   logic [7:0]    rx_dat = '0;
   logic          rx_vld = 1'b0;
   logic          rx_rdy, loading, done, err;
   logic [AW:0]   word_cnt;

   prog_mem_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .fetch_en_i(fetch_en), .fetch_adr_i(fetch_adr),
      .instr_o(instr), .instr_vld_o(instr_vld),
      .load_start_i(load_start), .rx_dat_i(rx_dat), .rx_vld_i(rx_vld),
      .rx_rdy_o(rx_rdy), .loading_o(loading), .done_o(done), .err_o(err),
      .word_cnt_o(word_cnt)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] model_mem [DEP];
   bit            model_valid [DEP];
   logic [AW:0]   exp_cnt = '0;
   logic          exp_err = 1'b0;
   bit            exp_complete = 1'b0;
   int            exp_done_total = 0;
   int            done_seen = 0;
   int            total = 0;
   int            bad = 0;

   always @(negedge clk) if (rst_n && done === 1'b1) done_seen++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: what a (possibly truncated) stream leaves behind after a start.
   task automatic model_apply(input bq_t q);
      int len, nw;
      exp_cnt = '0;
      exp_err = 1'b0;
      exp_complete = 1'b0;
      if (q.size() >= 2) begin
         len = int'(q[0]) + 256 * int'(q[1]);
         if (len == 0) exp_complete = 1'b1;
         else if (len > DEP) exp_err = 1'b1;
         else begin
            nw = (q.size() - 2) / 4;
            if (nw > len) nw = len;
            for (int w = 0; w < nw; w++) begin
               model_mem[w] = {q[2+4*w+3], q[2+4*w+2], q[2+4*w+1], q[2+4*w]};
               model_valid[w] = 1'b1;
            end
            exp_cnt = (AW+1)'(nw);
            exp_complete = (nw == len);
         end
      end
      if (exp_complete) exp_done_total++;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit thr);
      if (thr) begin
         repeat ($urandom_range(0, 2)) begin
            rx_vld = 1'b0;
            rx_dat = 8'($urandom);
            tick();
         end
      end
      rx_vld = 1'b1;
      rx_dat = b;
      tick();
      rx_vld = 1'b0;
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic stream_load(input bq_t q, input bit thr);
      foreach (q[i]) send_byte(q[i], thr);
      model_apply(q);
   endtask

   task automatic do_load(input bq_t q, input bit thr);
      pulse_start();
      stream_load(q, thr);
   endtask

   task automatic end_checks();
      chk("done_pulse", done, exp_complete);
      chk("loading_end", loading, 1'b0);
      chk("err_end", err, exp_err);
      chk("word_cnt_end", word_cnt, exp_cnt);
      tick();
      chk("done_one_cycle", done, 1'b0);
      tick();
      chk("done_count", done_seen, exp_done_total);
   endtask

   task automatic fetch_chk(input logic [AW-1:0] a, input logic [DW-1:0] expv, input string tag);
      fetch_en = 1'b1;
      fetch_adr = a;
      tick();
      fetch_en = 1'b0;
      chk({tag, "_vld"}, instr_vld, 1'b1);
      chk(tag, instr, expv);
   endtask

   task automatic check_all_mem();
      for (int a = 0; a < DEP; a++)
         if (model_valid[a]) fetch_chk(AW'(a), model_mem[a], "mem_image");
   endtask

   initial begin
      bq_t q;
      int n;
      foreach (model_valid[i]) model_valid[i] = 1'b0;

      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("rst_vld", instr_vld, 1'b0);
      chk("rst_loading", loading, 1'b0);
      chk("rst_rdy", rx_rdy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_cnt", word_cnt, '0);

      // asynchronous reset while waiting for the length high byte
      pulse_start();
      send_byte(8'h05, 1'b0);
      chk("len1_loading", loading, 1'b1);
      chk("len1_rdy", rx_rdy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_loading", loading, 1'b0);
      chk("async_rst_rdy", rx_rdy, 1'b0);
      chk("async_rst_cnt", word_cnt, '0);
      #1 rst_n = 1'b1;
      tick();

      // normal two-word load
      q = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      do_load(q, 1'b0);
      end_checks();
      fetch_chk(1, 32'hDEADBEEF, "fetch_adr1");
      fetch_chk(0, 32'h12345678, "fetch_adr0");

      // length beyond depth
      q = {8'h11, 8'h00};
      do_load(q, 1'b0);
      end_checks();
      fetch_chk(0, 32'h12345678, "err_no_write");
      pulse_start();
      chk("err_cleared", err, 1'b0);
      chk("restart_loading", loading, 1'b1);

      // zero length
      q = {8'h00, 8'h00};
      stream_load(q, 1'b0);
      end_checks();

      // abort after one word plus two bytes
      pulse_start();
      q = {8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      stream_load(q, 1'b0);
      chk("abort_mid_cnt", word_cnt, exp_cnt);
      q = {8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      do_load(q, 1'b0);
      end_checks();
      fetch_chk(0, 32'hDDCCBBAA, "abort_adr0");
      fetch_chk(1, 32'hDEADBEEF, "abort_adr1");

      // restart coincident with a byte: the byte must be dropped
      pulse_start();
      q = {8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};
      stream_load(q, 1'b0);
      rx_vld = 1'b1;
      rx_dat = 8'h07;
      load_start = 1'b1;
      tick();
      rx_vld = 1'b0;
      load_start = 1'b0;
      q = {8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
      stream_load(q, 1'b0);
      end_checks();
      fetch_chk(0, 32'h04030201, "coincident_adr0");

      // randomized, throttled full load
      n = $urandom_range(4, DEP);
      q = {};
      q.push_back(8'(n));
      q.push_back(8'h00);
      for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
      do_load(q, 1'b1);
      end_checks();
      check_all_mem();

      // reset after three words of an eight-word load
      q = {};
      q.push_back(8'h08);
      q.push_back(8'h00);
      for (int i = 0; i < 12; i++) q.push_back(8'($urandom));
      do_load(q, 1'b1);
      chk("pre_rst_cnt", word_cnt, exp_cnt);
      chk("pre_rst_loading", loading, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("midload_rst_cnt", word_cnt, '0);
      chk("midload_rst_loading", loading, 1'b0);
      #1 rst_n = 1'b1;
      tick();
      check_all_mem();

      // bytes in RUN are ignored; out-of-range fetch returns zero
      rx_vld = 1'b1;
      repeat (3) begin
         rx_dat = 8'($urandom);
         tick();
      end
      rx_vld = 1'b0;
      chk("run_rdy", rx_rdy, 1'b0);
      chk("run_loading", loading, 1'b0);
      chk("run_cnt", word_cnt, '0);
      fetch_chk(20, '0, "fetch_oob");
      tick();
      chk("idle_vld", instr_vld, 1'b0);
      chk("idle_instr", instr, '0);

      // fetch on the start cycle completes; fetches during load do not
      fetch_en = 1'b1;
      fetch_adr = 1;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      fetch_adr = 0;
      chk("start_fetch_vld", instr_vld, 1'b1);
      chk("start_fetch_data", instr, model_mem[1]);
      tick();
      fetch_en = 1'b0;
      chk("load_fetch_vld", instr_vld, 1'b0);
      chk("load_fetch_instr", instr, '0);
      q = {8'h00, 8'h00};
      stream_load(q, 1'b0);
      end_checks();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
- Parametrised instruction memory with an integrated serial loader.
- Normal run mode: serves CPU instruction fetches with 1-cycle read latency.
- Load mode: entered on request. Assembles a length-prefixed byte stream from the UART receiver into DATA_W-bit words and writes them sequentially from address 0.
- Sits between ifetch and the UART receiver. It generalises the fixed 32-bit/14-bit fetch/programmer mux with a framing state machine, a length check, a word counter and status flags.

Parameters:
- DATA_W, 32, instruction word width; must be a multiple of 8, range 8..64.
- ADDR_W, 14, word address width; must be ≤ 16.
- DEPTH, 16384, number of words; must be ≤ 2**ADDR_W.

Ports:
- clk_i  input  1  single clock for fetch, load and memory.
- rst_n_i  input  1  asynchronous active-low reset.
- fetch_en_i  input  1  fetch request, valid in RUN only.
- fetch_adr_i  input  ADDR_W  word address for fetch.
- instr_o  output  DATA_W  fetched instruction (registered).
- instr_vld_o  output  1  instr_o valid this cycle.
- load_start_i  input  1  1-cycle pulse; start or restart a load.
- rx_dat_i  input  8  received byte.
- rx_vld_i  input  1  byte valid.
- rx_rdy_o  output  1  loader accepts byte.
- loading_o  output  1  high while not in RUN; CPU must stall.
- done_o  output  1  1-cycle pulse on successful load completion.
- err_o  output  1  sticky length error.
- word_cnt_o  output  ADDR_W+1  words written in the current or last load.

Behaviour:
- Reset (async assert, sync release): state=RUN. All outputs 0, except rx_rdy_o=0 and loading_o=0. Counters, lane index and shift register are cleared. Memory contents are NOT cleared.
- States: RUN, LEN0, LEN1, DATA.
- A byte is accepted when rx_vld_i & rx_rdy_o. rx_rdy_o=1 in LEN0, LEN1 and DATA; 0 in RUN.
- loading_o=1 in any state other than RUN (combinational from state).
- RUN:
  - instr_o/instr_vld_o are registered: on fetch_en_i at cycle N, mem[fetch_adr_i] appears at N+1 with instr_vld_o=1.
  - If fetch_adr_i ≥ DEPTH, instr_o=0 with instr_vld_o=1.
  - load_start_i → LEN0; word_cnt_o←0, wr_adr←0, lane←0, err_o←0.
- Leaving RUN: any fetch issued on the cycle load_start_i is taken still completes next cycle. After that, instr_vld_o=0 and instr_o=0 until RUN is re-entered.
- LEN0: accepted byte → len[7:0]; go to LEN1.
- LEN1: accepted byte → len[15:8]. Then:
  - len==0: → RUN, done_o pulses the next cycle.
  - len > DEPTH: err_o←1, → RUN, no memory write, no done_o.
  - otherwise: → DATA.
- DATA:
  - Words are assembled little-endian: byte k of the word goes to bits [8k+7:8k]; lane counts 0..DATA_W/8-1.
  - On acceptance of the last lane: write the assembled word to mem[wr_adr] that same clock edge, wr_adr+1, word_cnt_o+1, lane←0.
  - When the incremented count equals len: → RUN, done_o=1 for exactly 1 cycle (the cycle after the final write). The final word is readable by a fetch issued in that cycle.
- load_start_i while not in RUN: abort and restart at LEN0. Any partial word is discarded; already-written words remain in memory; counters clear; err_o clears.
- Simultaneous load_start_i and a byte acceptance: load_start_i wins and the byte is dropped.
- Reset mid-load: → RUN. Memory holds whatever was written; word_cnt_o=0.
- Bytes arriving in RUN are not accepted (rx_rdy_o=0) and have no effect.
- Memory is inferred as single-clock RAM with one write port (loader) and one registered read port (fetch). No read/write conflict exists, because fetch is only serviced in RUN.

Test Plan:
- Reset with DATA_W=32: assert rst_n_i=0 mid-cycle → immediately state RUN, loading_o=0, rx_rdy_o=0, instr_vld_o=0, done_o=0, err_o=0, word_cnt_o=0.
- Normal load: load_start_i, bytes 02 00 | 78 56 34 12 | EF BE AD DE → mem[0]=0x12345678, mem[1]=0xDEADBEEF, word_cnt_o=2, one done_o pulse, loading_o falls. Fetch adr 1 → instr_o=0xDEADBEEF, instr_vld_o=1 one cycle later.
- Length error with DEPTH=16: bytes 11 00 → err_o=1, return to RUN, no done_o, mem[0] unchanged. The next load_start_i clears err_o.
- Zero length: bytes 00 00 → done_o pulse, word_cnt_o=0, no write.
- Abort: after 1 full word plus 2 bytes, pulse load_start_i, then stream 01 00 AA BB CC DD → mem[0]=0xDDCCBBAA, word_cnt_o=1; the partial bytes leave no trace. Repeat with load_start_i coincident with a byte: that byte is dropped.
- Reset mid-load plus throttled stream: rx_vld_i toggled randomly yields an identical memory image. rst_n_i asserted after 3 words → RUN, the 3 words remain readable by fetch, word_cnt_o=0.
